rgb_sbit_to_word: RTL and testbench
===================================

Name: rgb_sbit_to_word

Overview:
Serial-to-parallel converter in the RGB-to-RGBW pipeline. It sits downstream of the serial-bit decoder (one strobe per decoded WS2812-style bit or stream-reset event) and upstream of the write FIFO. It packs 24 decoded bits (one LED's GRB value) into a 32-bit word and writes it to the FIFO with a one-clock strobe. Stream-reset events produce a marker word. Writes attempted while the FIFO is full are dropped and latched as an overflow error.

Parameters:
- BITS_PER_WORD, 24, decoded bits packed per output word (1..31).
- WORD_WIDTH, 32, output word width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_strobe  in  1  level; asserted 1..N clocks per event; one event per rising edge.
- in_sbit_value  in  1  bit value; sampled on the strobe's rising-edge cycle when in_stream_reset=0.
- in_stream_reset  in  1  sampled with the strobe; 1 = stream reset (>=50 us idle line).
- in_wr_fifo_full  in  1  1 = FIFO cannot accept a write this clock.
- out_word  out  32  word presented to the FIFO; valid when out_strobe=1.
- out_strobe  out  1  one-clock write pulse.
- out_wr_fifo_overflow  out  1  sticky error flag.

Behaviour:
- Reset (async, rst=1) clears: out_word=0, out_strobe=0, out_wr_fifo_overflow=0, bit counter=0, shift register=0, strobe-edge history=0. The clock must not affect state while rst=1.
- Event detect: register in_strobe. Event = in_strobe & ~in_strobe_q. A strobe held for 1, 2, 3 or 4+ clocks yields exactly one event. in_sbit_value and in_stream_reset are sampled in the event cycle only.
- Data event (in_stream_reset=0): shift = {shift[BITS_PER_WORD-2:0], in_sbit_value}, so the first bit lands at MSB. Counter increments.
- Word complete: when the data event brings counter to BITS_PER_WORD, the word is emitted. out_word = {8'h00, shift_next[23:0]}, bit 31 = 0. Counter returns to 0.
- Stream-reset event (in_stream_reset=1, in_sbit_value ignored):
  - Any partial bits (counter 0..23) are discarded; counter and shift clear.
  - A marker word is emitted: out_word = 32'h8000_0000 | count of discarded bits in [4:0].
- Emit rule, evaluated in the clock after the event cycle (latency 1 clock, edge to out_strobe):
  - If in_wr_fifo_full=0: out_strobe=1 for one clock, with out_word driven.
  - If in_wr_fifo_full=1: no strobe, the word is dropped, and out_wr_fifo_overflow is set to 1.
- out_wr_fifo_overflow stays set until rst; it does not stall counting.
- out_word holds its last value when out_strobe=0.
- Events are spaced at least 2 clocks apart by the upstream block. A new event arriving in the emit cycle is still processed; there is no back-pressure to upstream.
- Simultaneous rst and event: rst wins.

Decomposition:
- Shared package rgb_pkg: BITS_PER_WORD, WORD_WIDTH, STREAM_RESET_MARKER = 32'h8000_0000, and the timing constants STREAM_RESET_CLKS = 4800 and SAMPLE_TIME_CLKS = 57 (96 MHz basis).
- Optional sub-module rgb_edge_detect (rising-edge pulse of in_strobe). Everything else stays in one module.

Test Plan:
- Reset pulse: after rst 1->0, all outputs are 0 and the counter is 0.
- Strobes of 1, 2, 3 and 4 clocks with values 0,1,0,1, then 20 more bits of 1 -> exactly one out_strobe with out_word = 32'h005F_FFFF.
- Stream reset with 0 partial bits -> one out_strobe, out_word = 32'h8000_0000. Stream reset after 1 bit -> 32'h8000_0001. Stream reset after 23 bits -> 32'h8000_0017, with no data word emitted.
- 48 alternating bits 1,0,1,0... -> two strobes, each out_word = 32'h00AA_AAAA, each 1 clock after the 24th bit's rising edge.
- Fill 24 bits with in_wr_fifo_full=1 -> no out_strobe and out_wr_fifo_overflow=1. The flag stays 1 after full deasserts, and the next 24 bits still emit normally.
- Assert rst mid-word (12 bits loaded), then send 24 bits -> the word contains only the post-reset bits and out_wr_fifo_overflow is cleared.

Source files
------------

// File: rtl/rgb_sbit_to_word_pkg.sv
// Shared constants and types for the RGB-to-RGBW serial pipeline.
package rgb_pkg;

  localparam int unsigned BITS_PER_WORD       = 24;
  localparam int unsigned WORD_WIDTH          = 32;
  localparam logic [31:0] STREAM_RESET_MARKER = 32'h8000_0000;
  // Line timing at a 96 MHz system clock
  localparam int unsigned STREAM_RESET_CLKS   = 4800;
  localparam int unsigned SAMPLE_TIME_CLKS    = 57;

  typedef enum logic [1:0] {
    EV_NONE,
    EV_DATA,
    EV_RESET
  } event_kind_t;

endpackage

// File: rtl/rgb_sbit_to_word_if.sv
// Decoded-bit input and FIFO write port of the bit-to-word packer.
interface rgb_sbit_to_word_if
  import rgb_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = rgb_pkg::WORD_WIDTH
);

  logic                  in_strobe;
  logic                  in_sbit_value;
  logic                  in_stream_reset;
  logic                  in_wr_fifo_full;
  logic [WORD_WIDTH-1:0] out_word;
  logic                  out_strobe;
  logic                  out_wr_fifo_overflow;

  modport slave (
    input  in_strobe, in_sbit_value, in_stream_reset, in_wr_fifo_full,
    output out_word, out_strobe, out_wr_fifo_overflow
  );

  modport master (
    output in_strobe, in_sbit_value, in_stream_reset, in_wr_fifo_full,
    input  out_word, out_strobe, out_wr_fifo_overflow
  );

endinterface

// File: rtl/rgb_sbit_to_word_edge_detect.sv
// Single-cycle pulse on the rising edge of a level input.
module rgb_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic i_level,
  output logic o_rise
);

  logic r_level_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_level_q <= 1'b0;
    else     r_level_q <= i_level;
  end

  assign o_rise = i_level & ~r_level_q;

endmodule

// File: rtl/rgb_sbit_to_word.sv
// Packs decoded serial bits into FIFO words; stream resets emit a marker
// word carrying the number of discarded partial bits.
module rgb_sbit_to_word #(
  parameter int unsigned BITS_PER_WORD = rgb_pkg::BITS_PER_WORD,
  parameter int unsigned WORD_WIDTH    = rgb_pkg::WORD_WIDTH
) (
  input logic              clk,
  input logic              rst,
  rgb_sbit_to_word_if.slave bus
);

  import rgb_pkg::*;

  localparam int unsigned CNT_W = $clog2(BITS_PER_WORD + 1);

  logic                     w_event;
  event_kind_t              w_kind;
  logic [CNT_W-1:0]         r_cnt;
  logic [CNT_W-1:0]         w_cnt_next;
  logic [BITS_PER_WORD-1:0] r_shift;
  logic [BITS_PER_WORD-1:0] w_shift_next;
  logic                     w_emit;
  logic [WORD_WIDTH-1:0]    w_word;
  logic [WORD_WIDTH-1:0]    r_word;
  logic                     r_strobe;
  logic                     r_overflow;

  rgb_edge_detect u_edge (
    .clk     (clk),
    .rst     (rst),
    .i_level (bus.in_strobe),
    .o_rise  (w_event)
  );

  always_comb begin
    w_kind = EV_NONE;
    if (w_event) w_kind = bus.in_stream_reset ? EV_RESET : EV_DATA;
  end

  always_comb begin
    w_cnt_next   = r_cnt;
    w_shift_next = r_shift;
    w_emit       = 1'b0;
    w_word       = '0;
    case (w_kind)
      EV_DATA: begin
        // Concatenate-and-truncate keeps the MSB-first shift legal for any width
        w_shift_next = BITS_PER_WORD'({r_shift, bus.in_sbit_value});
        if (r_cnt == CNT_W'(BITS_PER_WORD - 1)) begin
          w_cnt_next = '0;
          w_emit     = 1'b1;
          w_word     = WORD_WIDTH'(w_shift_next);
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      EV_RESET: begin
        w_cnt_next   = '0;
        w_shift_next = '0;
        w_emit       = 1'b1;
        w_word       = WORD_WIDTH'(STREAM_RESET_MARKER) | WORD_WIDTH'(r_cnt);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_shift    <= '0;
      r_word     <= '0;
      r_strobe   <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_next;
      r_shift  <= w_shift_next;
      r_strobe <= 1'b0;
      if (w_emit) begin
        if (bus.in_wr_fifo_full) begin
          r_overflow <= 1'b1;
        end else begin
          r_strobe <= 1'b1;
          r_word   <= w_word;
        end
      end
    end
  end

  assign bus.out_word             = r_word;
  assign bus.out_strobe           = r_strobe;
  assign bus.out_wr_fifo_overflow = r_overflow;

endmodule

// File: tb/tb_rgb_sbit_to_word.sv
// Randomized self-checking bench for rgb_sbit_to_word against a bit-list model.
module tb_rgb_sbit_to_word;

  import rgb_pkg::*;

  localparam int unsigned BPW = BITS_PER_WORD;
  localparam int unsigned WW  = WORD_WIDTH;

  logic clk = 1'b0;
  logic rst = 1'b1;

  rgb_sbit_to_word_if #(.WORD_WIDTH(WW)) bus ();

  rgb_sbit_to_word #(
    .BITS_PER_WORD (BPW),
    .WORD_WIDTH    (WW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Reference model: pending bits kept as a list, words built arithmetically
  bit          m_bits[$];
  logic [31:0] m_last;
  bit          m_ovf;
  int unsigned n_exp;
  int unsigned n_obs = 0;

  always @(negedge clk) if (bus.out_strobe) n_obs++;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic model_clear();
    m_bits.delete();
    m_last = '0;
    m_ovf  = 1'b0;
  endtask

  task automatic send_ev(input bit v, input bit sr, input int hold, input int gap);
    bit          emit;
    logic [31:0] word;
    longint unsigned acc;
    emit = 1'b0;
    word = '0;
    bus.in_strobe       = 1'b1;
    bus.in_sbit_value   = v;
    bus.in_stream_reset = sr;
    if (sr) begin
      emit = 1'b1;
      word = 32'h8000_0000 + m_bits.size();
      m_bits.delete();
    end else begin
      m_bits.push_back(v);
      if (m_bits.size() == BPW) begin
        acc = 0;
        foreach (m_bits[k]) acc = acc * 2 + m_bits[k];
        emit = 1'b1;
        word = 32'(acc);
        m_bits.delete();
      end
    end
    if (emit && bus.in_wr_fifo_full) begin
      emit  = 1'b0;
      m_ovf = 1'b1;
    end
    if (emit) begin
      m_last = word;
      n_exp++;
    end
    @(posedge clk); #1;
    chk("emit_strobe", 32'(bus.out_strobe), 32'(emit));
    chk("out_word", bus.out_word, m_last);
    chk("overflow", 32'(bus.out_wr_fifo_overflow), 32'(m_ovf));
    // Value and reset lines are don't-care outside the event cycle
    bus.in_sbit_value   = 1'($urandom);
    bus.in_stream_reset = 1'($urandom);
    for (int i = 1; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_quiet", 32'(bus.out_strobe), 32'd0);
    end
    bus.in_strobe = 1'b0;
    for (int i = 0; i < gap; i++) begin
      @(posedge clk); #1;
      chk("gap_quiet", 32'(bus.out_strobe), 32'd0);
    end
  endtask

  task automatic send_bit(input bit v);
    send_ev(v, 1'b0, int'($urandom_range(1, 4)), int'($urandom_range(1, 3)));
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("rst_async_word", bus.out_word, 32'd0);
    chk("rst_async_strobe", 32'(bus.out_strobe), 32'd0);
    chk("rst_async_ovf", 32'(bus.out_wr_fifo_overflow), 32'd0);
    bus.in_strobe       = 1'b1;
    bus.in_stream_reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_strobe", 32'(bus.out_strobe), 32'd0);
    chk("rst_hold_word", bus.out_word, 32'd0);
    bus.in_strobe       = 1'b0;
    bus.in_stream_reset = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
    @(posedge clk); #1;
    chk("post_rst_strobe", 32'(bus.out_strobe), 32'd0);
    chk("post_rst_ovf", 32'(bus.out_wr_fifo_overflow), 32'd0);
  endtask

  initial begin
    bus.in_strobe       = 1'b0;
    bus.in_sbit_value   = 1'b0;
    bus.in_stream_reset = 1'b0;
    bus.in_wr_fifo_full = 1'b0;
    n_exp = 0;
    model_clear();
    repeat (3) @(posedge clk);
    do_reset();

    // Held strobes of 1..4 clocks each count once
    send_ev(1'b0, 1'b0, 1, 2);
    send_ev(1'b1, 1'b0, 2, 1);
    send_ev(1'b0, 1'b0, 3, 1);
    send_ev(1'b1, 1'b0, 4, 1);
    for (int i = 0; i < 20; i++) send_bit(1'b1);
    chk("word_5fffff", bus.out_word, 32'h005F_FFFF);

    send_ev(1'b0, 1'b1, 2, 2);
    chk("marker_0", bus.out_word, 32'h8000_0000);
    send_bit(1'b1);
    send_ev(1'b1, 1'b1, 1, 2);
    chk("marker_1", bus.out_word, 32'h8000_0001);
    for (int i = 0; i < 23; i++) send_bit(1'($urandom));
    send_ev(1'b0, 1'b1, 3, 2);
    chk("marker_23", bus.out_word, 32'h8000_0017);

    for (int i = 0; i < 48; i++) begin
      send_bit(1'((i % 2) == 0));
      if (i == 23 || i == 47) chk("word_aaaaaa", bus.out_word, 32'h00AA_AAAA);
    end

    bus.in_wr_fifo_full = 1'b1;
    for (int i = 0; i < 24; i++) send_bit(1'($urandom));
    bus.in_wr_fifo_full = 1'b0;
    @(posedge clk); #1;
    chk("ovf_sticky", 32'(bus.out_wr_fifo_overflow), 32'd1);
    for (int i = 0; i < 24; i++) send_bit(1'($urandom));

    for (int i = 0; i < 12; i++) send_bit(1'b1);
    do_reset();
    for (int i = 0; i < 24; i++) send_bit(1'(i >= 12));
    chk("post_rst_word", bus.out_word, 32'h0000_0FFF);

    for (int i = 0; i < 400; i++) begin
      bus.in_wr_fifo_full = ($urandom_range(0, 7) == 0);
      send_ev(1'($urandom), ($urandom_range(0, 19) == 0),
              int'($urandom_range(1, 4)), int'($urandom_range(1, 3)));
    end
    bus.in_wr_fifo_full = 1'b0;

    repeat (2) @(posedge clk);
    chk("strobe_count", n_obs, n_exp);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
